// File: rtl/adc_sample_fifo_pkg.sv
// Shared types and defaults for the ADC sample output FIFO.
package adc_sample_fifo_pkg;

  localparam int unsigned FIFO_DEPTH_LOG2_DEFAULT = 4;
  localparam int unsigned SAMPLE_BW               = 16;

  typedef logic signed [SAMPLE_BW-1:0]      sample_t;
  typedef logic [FIFO_DEPTH_LOG2_DEFAULT:0] fifo_level_t;

endpackage

// File: rtl/fifo_mem_1w1r.sv
// 1-write/1-read register-array memory with registered, held read data.
module fifo_mem_1w1r #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rstx,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rd_data;

  // Storage array: written on accepted writes, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read register: sees pre-write contents on a same-address write/read, holds between reads.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/adc_sample_fifo.sv
// Circular sample FIFO between the ADC back-end and the host register side.
module adc_sample_fifo
  import adc_sample_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEFAULT,
  parameter int unsigned BW         = SAMPLE_BW
) (
  input  logic                  clk,
  input  logic                  rstx,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  data_in_valid,
  input  logic [BW-1:0]         data_in,
  input  logic                  rd_req,
  input  logic [DEPTH_LOG2:0]   watermark,
  input  logic                  clear_flags,
  output logic                  rd_data_valid,
  output logic [BW-1:0]         rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  ovf,
  output logic                  udf,
  output logic                  irq
);

  localparam logic [DEPTH_LOG2:0] LevelFull = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [DEPTH_LOG2-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   r_level,  w_level_nxt;
  logic                  r_ovf,    w_ovf_nxt;
  logic                  r_udf,    w_udf_nxt;
  logic                  r_rd_valid;

  logic w_empty, w_full;
  logic w_rd_acc, w_wr_acc;
  logic w_ovf_evt, w_udf_evt;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LevelFull);

  // Acceptance uses pre-edge level, so a same-cycle write cannot satisfy a read on empty.
  assign w_rd_acc  = rd_req & ~w_empty & ~clear;
  assign w_wr_acc  = enable & data_in_valid & (~w_full | w_rd_acc) & ~clear;
  assign w_ovf_evt = enable & data_in_valid & w_full & ~w_rd_acc;
  assign w_udf_evt = rd_req & w_empty;

  // Next-state for pointers, level and sticky flags; clear overrides everything.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_level_nxt  = r_level;
    w_ovf_nxt    = r_ovf;
    w_udf_nxt    = r_udf;
    if (clear) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_level_nxt  = '0;
      w_ovf_nxt    = 1'b0;
      w_udf_nxt    = 1'b0;
    end else begin
      if (w_wr_acc) w_wr_ptr_nxt = r_wr_ptr + 1'b1;
      if (w_rd_acc) w_rd_ptr_nxt = r_rd_ptr + 1'b1;
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   w_level_nxt = r_level + 1'b1;
        2'b01:   w_level_nxt = r_level - 1'b1;
        default: w_level_nxt = r_level;
      endcase
      // A new event beats a same-cycle clear_flags.
      if (w_ovf_evt)        w_ovf_nxt = 1'b1;
      else if (clear_flags) w_ovf_nxt = 1'b0;
      if (w_udf_evt)        w_udf_nxt = 1'b1;
      else if (clear_flags) w_udf_nxt = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_level    <= w_level_nxt;
      r_ovf      <= w_ovf_nxt;
      r_udf      <= w_udf_nxt;
      r_rd_valid <= w_rd_acc;
    end
  end

  fifo_mem_1w1r #(
    .AW (DEPTH_LOG2),
    .DW (BW)
  ) u_mem (
    .clk     (clk),
    .rstx    (rstx),
    .wr_en   (w_wr_acc),
    .wr_addr (r_wr_ptr),
    .wr_data (data_in),
    .rd_en   (w_rd_acc),
    .rd_addr (r_rd_ptr),
    .rd_data (rd_data)
  );

  assign rd_data_valid = r_rd_valid;
  assign level         = r_level;
  assign empty         = w_empty;
  assign full          = w_full;
  assign ovf           = r_ovf;
  assign udf           = r_udf;
  assign irq           = (watermark != '0) && (r_level >= watermark);

endmodule
